// File: rtl/exact_fp_pkg.sv
// exact_fp_pkg: shared geometry helpers and classification types for the exact FP multiplier.
package exact_fp_pkg;

  function automatic int bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  function automatic int data_width(input int exp_width, input int frac_width);
    return 1 + exp_width + frac_width;
  endfunction

  function automatic int mant_width(input int frac_width);
    return 2 * (frac_width + 1);
  endfunction

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

  typedef struct packed {
    logic inf;
    logic nan;
  } fp_flags_t;

endpackage

// File: rtl/exact_fp_unpack.sv
// exact_fp_unpack: splits one operand into sign, effective exponent, significand and class bits.
module exact_fp_unpack
  import exact_fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int FRAC_WIDTH = 23,
  localparam int DATA_WIDTH = data_width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] op,
  output logic                  sign,
  output logic [EXP_WIDTH-1:0]  eff_exp,
  output logic [FRAC_WIDTH:0]   significand,
  output fp_class_t             cls
);
  logic [EXP_WIDTH-1:0] e;
  logic [FRAC_WIDTH-1:0] f;
  logic hidden;
  assign sign = op[DATA_WIDTH-1];
  assign e = op[FRAC_WIDTH +: EXP_WIDTH];
  assign f = op[FRAC_WIDTH-1:0];
  assign hidden = |e;
  // subnormals share the minimum normal exponent, just without the hidden bit
  assign eff_exp = hidden ? e : EXP_WIDTH'(1);
  assign significand = {hidden, f};
  assign cls.zero = !hidden && f == '0;
  assign cls.inf = &e && f == '0;
  assign cls.nan = &e && f != '0;
endmodule

// File: rtl/exact_fp_mult_pipe.sv
// exact_fp_mult_pipe: pipelined unrounded FP multiplier with valid/ready flow control.
// Define EXACT_FP_MULT_SPECIAL_EN to classify all-ones exponents and drive OutInf/OutNaN.
module exact_fp_mult_pipe
  import exact_fp_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int STAGES = 2,
  parameter int TAG_WIDTH = 4,
  localparam int DATA_WIDTH = data_width(EXP_WIDTH, FRAC_WIDTH),
  localparam int MANT_WIDTH = mant_width(FRAC_WIDTH)
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic [DATA_WIDTH-1:0]       In1,
  input  logic [DATA_WIDTH-1:0]       In2,
  input  logic [TAG_WIDTH-1:0]        InTag,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic                        MultSign,
  output logic signed [EXP_WIDTH+1:0] MultExponent,
  output logic [MANT_WIDTH-1:0]       MultMantissa,
`ifdef EXACT_FP_MULT_SPECIAL_EN
  output logic                        OutInf,
  output logic                        OutNaN,
`endif
  output logic [TAG_WIDTH-1:0]        OutTag
);
  localparam int BIAS = bias(EXP_WIDTH);
  localparam int EW2 = EXP_WIDTH + 2;

  typedef struct packed {
    logic                        sign;
    logic signed [EXP_WIDTH+1:0] exponent;
    logic [MANT_WIDTH-1:0]       mantissa;
    logic [TAG_WIDTH-1:0]        tag;
    fp_flags_t                   flags;
  } payload_t;

  logic s1, s2;
  logic [EXP_WIDTH-1:0] x1, x2;
  logic [FRAC_WIDTH:0] m1, m2;
  fp_class_t c1, c2;
  payload_t prod;
  logic [STAGES-1:0] vld;
  payload_t dat [STAGES];

  exact_fp_unpack #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_unpack1 (
    .op(In1), .sign(s1), .eff_exp(x1), .significand(m1), .cls(c1)
  );
  exact_fp_unpack #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_unpack2 (
    .op(In2), .sign(s2), .eff_exp(x2), .significand(m2), .cls(c2)
  );

  // two guard bits keep the biased sum free of wrap for every operand pair
  always_comb begin
    prod.sign = s1 ^ s2;
    prod.exponent = EW2'(x1) + EW2'(x2) - EW2'(BIAS);
    prod.mantissa = MANT_WIDTH'(m1) * MANT_WIDTH'(m2);
    prod.tag = InTag;
`ifdef EXACT_FP_MULT_SPECIAL_EN
    prod.flags.nan = c1.nan || c2.nan || (c1.inf && c2.zero) || (c2.inf && c1.zero);
    prod.flags.inf = (c1.inf || c2.inf) && !prod.flags.nan;
`else
    prod.flags = '0;
`endif
  end

`ifndef EXACT_FP_MULT_SPECIAL_EN
  logic unused_cls;
  assign unused_cls = ^{c1, c2};
`endif

  // a slice moves when any slice downstream of it has room or the consumer drains
  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    logic in_v;
    payload_t in_d;
    logic adv;
    if (s == 0) begin : g_head
      assign in_v = InValid;
      assign in_d = prod;
    end else begin : g_tail
      assign in_v = vld[s-1];
      assign in_d = dat[s-1];
    end
    assign adv = OutReady || !(&vld[STAGES-1:s]);
    always_ff @(posedge Clk)
      if (!Rst_n) begin
        vld[s] <= 1'b0;
        dat[s] <= '0;
      end else if (adv) begin
        vld[s] <= in_v;
        if (in_v) dat[s] <= in_d;
      end
  end

  assign InReady = OutReady || !(&vld);
  assign OutValid = vld[STAGES-1];
  assign MultSign = dat[STAGES-1].sign;
  assign MultExponent = dat[STAGES-1].exponent;
  assign MultMantissa = dat[STAGES-1].mantissa;
  assign OutTag = dat[STAGES-1].tag;
`ifdef EXACT_FP_MULT_SPECIAL_EN
  assign OutInf = dat[STAGES-1].flags.inf;
  assign OutNaN = dat[STAGES-1].flags.nan;
`endif
endmodule
